// File: rtl/rename_alloc_if.sv
// Rename allocator bus: RAT feedback, rename handshake, completion and commit-free ports.
// The master side is the surrounding pipeline and RAT; the slave side is the allocator.
interface rename_alloc_if #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int LR_WIDTH   = 4
);
    logic [NUM_LRS*ADDR_WIDTH-1:0] assignments;
    logic [NUM_LRS-1:0]            done_flags;
    logic                          rename_valid;
    logic [LR_WIDTH-1:0]           rename_lr;
    logic                          rename_ready;
    logic [ADDR_WIDTH-1:0]         rename_tag;
    logic [ADDR_WIDTH-1:0]         rename_old_tag;
    logic                          complete_valid;
    logic [ADDR_WIDTH-1:0]         complete_tag;
    logic                          free_valid;
    logic [ADDR_WIDTH-1:0]         free_tag;
    logic [NUM_LRS*ADDR_WIDTH-1:0] assignments_in;
    logic [NUM_LRS-1:0]            done_flags_in;
    logic [ADDR_WIDTH-1:0]         free_count;
    logic                          err;

    modport master (
        output assignments, done_flags, rename_valid, rename_lr,
               complete_valid, complete_tag, free_valid, free_tag,
        input  rename_ready, rename_tag, rename_old_tag,
               assignments_in, done_flags_in, free_count, err
    );

    modport slave (
        input  assignments, done_flags, rename_valid, rename_lr,
               complete_valid, complete_tag, free_valid, free_tag,
        output rename_ready, rename_tag, rename_old_tag,
               assignments_in, done_flags_in, free_count, err
    );
endinterface

// File: rtl/rename_alloc.sv
// Physical-tag free list and RAT next-state generator; RENAME_ALLOC_CHECK_EN adds double-free detection.
// Latency: all outputs combinational from inputs and free-list state; state moves on the firing clk edge.
// Backpressure: stall-only, rename_ready drops while the free list is empty.
module rename_alloc #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int LR_WIDTH   = 4
) (
    input logic           clk,
    input logic           rst,
    rename_alloc_if.slave bus
);
    localparam int                    NUM_PRS  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(NUM_PRS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [LR_WIDTH:0]     LR_LIMIT = (LR_WIDTH + 1)'(NUM_LRS);

    logic [ADDR_WIDTH-1:0] r_slot [NUM_PRS];
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_count;

    logic                          w_ready;
    logic                          w_lr_ok;
    logic                          w_alloc;
    logic                          w_free_ok;
    logic [ADDR_WIDTH-1:0]         w_head;
    logic [ADDR_WIDTH-1:0]         w_old_tag;
    logic [NUM_LRS*ADDR_WIDTH-1:0] w_assign_nxt;
    logic [NUM_LRS-1:0]            w_done_nxt;

    assign w_ready = (r_count != '0);
    assign w_lr_ok = ({1'b0, bus.rename_lr} < LR_LIMIT);
    assign w_alloc = bus.rename_valid && w_ready && w_lr_ok;
    assign w_head  = r_slot[r_rd_ptr];

`ifdef RENAME_ALLOC_CHECK_EN
    logic [NUM_PRS-1:0] r_in_list;
    logic               r_err;

    assign w_free_ok = bus.free_valid && (bus.free_tag != '0) && (r_count != FULL_CNT)
                       && !r_in_list[bus.free_tag];

    // The head is always in the list and an accepted free is not, so the two bit updates never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_list <= {{(NUM_PRS-1){1'b1}}, 1'b0};
            r_err     <= 1'b0;
        end else begin
            if (w_alloc)
                r_in_list[w_head] <= 1'b0;
            if (w_free_ok)
                r_in_list[bus.free_tag] <= 1'b1;
            if (bus.free_valid && !w_free_ok)
                r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_free_ok = bus.free_valid && (bus.free_tag != '0) && (r_count != FULL_CNT);
    assign bus.err   = 1'b0;
`endif

    // Rename wins over completion on the same LR: the new mapping has not been produced yet.
    always_comb begin
        w_old_tag    = '0;
        w_assign_nxt = bus.assignments;
        w_done_nxt   = bus.done_flags;
        for (int i = 0; i < NUM_LRS; i++) begin
            if (bus.complete_valid && (bus.assignments[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.complete_tag))
                w_done_nxt[i] = 1'b1;
            if (LR_WIDTH'(i) == bus.rename_lr) begin
                w_old_tag = bus.assignments[i*ADDR_WIDTH +: ADDR_WIDTH];
                if (w_alloc) begin
                    w_assign_nxt[i*ADDR_WIDTH +: ADDR_WIDTH] = w_head;
                    w_done_nxt[i]                            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PRS; k++)
                r_slot[k] <= (k < NUM_PRS - 1) ? ADDR_WIDTH'(k + 1) : '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= FULL_CNT;
            r_count  <= FULL_CNT;
        end else begin
            if (w_alloc)
                r_rd_ptr <= r_rd_ptr + ONE;
            if (w_free_ok) begin
                r_slot[r_wr_ptr] <= bus.free_tag;
                r_wr_ptr         <= r_wr_ptr + ONE;
            end
            case ({w_alloc, w_free_ok})
                2'b10:   r_count <= r_count - ONE;
                2'b01:   r_count <= r_count + ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.rename_ready   = w_ready;
    assign bus.rename_tag     = w_head;
    assign bus.rename_old_tag = w_old_tag;
    assign bus.assignments_in = w_assign_nxt;
    assign bus.done_flags_in  = w_done_nxt;
    assign bus.free_count     = r_count;
endmodule

// File: tb/tb_rename_alloc.sv
// Directed bench for rename_alloc with a queue-based free-list model and an allocation scoreboard.
module tb_rename_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rename_alloc_if #(.NUM_LRS(10), .ADDR_WIDTH(5), .LR_WIDTH(4)) bus ();

    rename_alloc #(.NUM_LRS(10), .ADDR_WIDTH(5), .LR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // The bench plays the RAT: it registers the allocator's next-state outputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.assignments <= '0;
            bus.done_flags  <= '1;
        end else begin
            bus.assignments <= bus.assignments_in;
            bus.done_flags  <= bus.done_flags_in;
        end
    end

    typedef struct {
        int tag;
        int old;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   q_free[$];
    exp_t sb[$];
    int   m_map  [10];
    bit   m_done [10];
    bit   m_inlist [32];
    bit   m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_free.delete();
        sb.delete();
        for (int k = 1; k < 32; k++) q_free.push_back(k);
        for (int i = 0; i < 10; i++) begin
            m_map[i]  = 0;
            m_done[i] = 1'b1;
        end
        for (int k = 0; k < 32; k++) m_inlist[k] = (k != 0);
        m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.rename_valid   = 1'b0;
        bus.rename_lr      = '0;
        bus.complete_valid = 1'b0;
        bus.complete_tag   = '0;
        bus.free_valid     = 1'b0;
        bus.free_tag       = '0;
    endtask

    task automatic step(input bit rv, input int lr, input bit cv, input int ct, input bit fv, input int ft);
        logic [49:0] ea;
        logic [9:0]  ed;
        bit          rdy;
        bit          alloc;
        bit          fok;
        exp_t        e;
        exp_t        got;
        @(posedge clk);
        #1;
        bus.rename_valid   = rv;
        bus.rename_lr      = 4'(lr);
        bus.complete_valid = cv;
        bus.complete_tag   = 5'(ct);
        bus.free_valid     = fv;
        bus.free_tag       = 5'(ft);
        rdy   = (q_free.size() != 0);
        alloc = rv && rdy && (lr < 10);
        fok   = fv && (ft != 0) && (q_free.size() < 31);
`ifdef RENAME_ALLOC_CHECK_EN
        if (fok && m_inlist[ft]) fok = 1'b0;
`endif
        for (int i = 0; i < 10; i++) begin
            ea[i*5 +: 5] = 5'(m_map[i]);
            ed[i]        = m_done[i];
            if (cv && (m_map[i] == ct)) ed[i] = 1'b1;
        end
        if (alloc) begin
            e.tag = q_free[0];
            e.old = m_map[lr];
            sb.push_back(e);
            ea[lr*5 +: 5] = 5'(e.tag);
            ed[lr]        = 1'b0;
        end
        @(negedge clk);
        chk("rename_ready", bus.rename_ready, rdy);
        chk("free_count", bus.free_count, q_free.size());
        chk("err", bus.err, m_err);
        chk("assignments_in", bus.assignments_in, ea);
        chk("done_flags_in", bus.done_flags_in, ed);
        if (rdy) chk("rename_tag_head", bus.rename_tag, q_free[0]);
        if (rv && lr < 10) chk("rename_old_tag", bus.rename_old_tag, m_map[lr]);
        if (bus.rename_valid && bus.rename_ready && lr < 10) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_alloc observed=tag%0h expected=no_allocation", bus.rename_tag);
            end
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk("sb_tag", bus.rename_tag, got.tag);
                chk("sb_old_tag", bus.rename_old_tag, got.old);
            end
        end
        for (int i = 0; i < 10; i++) begin
            m_map[i]  = int'(ea[i*5 +: 5]);
            m_done[i] = ed[i];
        end
        if (alloc) begin
            m_inlist[q_free[0]] = 1'b0;
            void'(q_free.pop_front());
        end
        if (fok) begin
            q_free.push_back(ft);
            m_inlist[ft] = 1'b1;
        end
`ifdef RENAME_ALLOC_CHECK_EN
        if (fv && !fok) m_err = 1'b1;
`endif
    endtask

    task automatic async_reset_check();
        #1;
        rst = 1'b1;
        idle_inputs();
        #1;
        model_reset();
        chk("rst_free_count", bus.free_count, 31);
        chk("rst_rename_tag", bus.rename_tag, 1);
        chk("rst_ready", bus.rename_ready, 1);
        chk("rst_err", bus.err, 0);
        chk("rst_assignments_in", bus.assignments_in, 50'h0);
        chk("rst_done_flags_in", bus.done_flags_in, 10'h3FF);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        step(1, 3, 1, 2, 0, 0);
        step(1, 12, 0, 0, 0, 0);
        for (int i = 0; i < 28; i++) step(1, i % 10, 1, i + 1, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, 2, 0, 0, 1, 5);
        step(1, 4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5);
        for (int t = 8; t <= 16; t++) step(0, 0, 0, 0, 1, t);
        step(1, 6, 0, 0, 1, 7);
        for (int i = 0; i < 10; i++) step(1, (i * 3) % 10, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 20);
        step(0, 0, 0, 0, 1, 21);
        step(0, 0, 0, 0, 1, 20);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 1, 0, 0, 0, 0);
        async_reset_check();
        step(0, 0, 0, 0, 1, 9);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4);
        step(1, 5, 0, 0, 0, 0);
        async_reset_check();
        step(1, 9, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        idle_inputs();
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
